// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BIT_IDX_W  = 4;
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned PARITY_IDX = 8;
  localparam int unsigned STOP_IDX   = FRAME_BITS - 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    REQUEST = 3'd2,
    SHIFT   = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5
  } ps2_state_e;

  function automatic int unsigned ps2_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_transmitter_if.sv
// Host-side command handshake of the PS/2 transmitter.
interface ps2_transmitter_if;
  import ps2_pkg::*;

  logic [DATA_W-1:0] txData;
  logic              txStart;
  logic              busy;
  logic              done;
  logic              ackError;
  logic              timeout;
  logic              rxInhibit;

  modport master (output txData, txStart,
                  input  busy, done, ackError, timeout, rxInhibit);
  modport slave  (input  txData, txStart,
                  output busy, done, ackError, timeout, rxInhibit);
endinterface

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizer for one PS/2 line with a registered falling-edge flag.
module ps2_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta;
  logic prev;

  // Idle PS/2 lines float high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
      fall  <= 1'b0;
    end else begin
      meta  <= line;
      level <= meta;
      prev  <= level;
      fall  <= prev & ~level;
    end
  end

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device frame transmitter (inhibit, request, 11-clock shift, ACK).
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_transmitter
  import ps2_pkg::*;
#(
  parameter int unsigned inhibitCycles = 480,
  parameter int unsigned timeoutCycles = 60000,
  parameter int unsigned counterBits   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ps2Clk,
  input  logic               ps2Data,
  output logic               ps2ClkLow,
  output logic               ps2DataLow,
  ps2_transmitter_if.slave   bus
);

  localparam int unsigned CNT_NEED = ps2_max(inhibitCycles, timeoutCycles);

  if (counterBits < 32 && CNT_NEED >= (32'd1 << counterBits)) begin : g_cnt_check
    $error("counterBits cannot hold the inhibit/timeout limit");
  end

  logic clk_level, clk_fall;
  logic data_level;
  logic data_fall_unused;

  ps2_edge_sync u_clk_sync (
    .clk   (clk),
    .rst_n (reset),
    .line  (ps2Clk),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_edge_sync u_data_sync (
    .clk   (clk),
    .rst_n (reset),
    .line  (ps2Data),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  ps2_state_e             state_q, state_d;
  logic [counterBits-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic                   parity_q, parity_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic                   clk_low_q, clk_low_d;
  logic                   data_low_q, data_low_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ack_err_q, ack_err_d;
  logic                   timeout_q, timeout_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      bit_idx_q  <= bit_idx_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    bit_idx_d  = bit_idx_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_err_d  = ack_err_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.txStart) begin
          shreg_d   = bus.txData;
          parity_d  = ~^bus.txData;
          cnt_d     = '0;
          ack_err_d = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          clk_low_d = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == counterBits'(inhibitCycles - 1)) begin
          cnt_d      = '0;
          clk_low_d  = 1'b0;
          data_low_d = 1'b1;
          bit_idx_d  = '0;
          state_d    = REQUEST;
        end else begin
          cnt_d = cnt_q + counterBits'(1);
        end
      end
      REQUEST: begin
        bit_idx_d = '0;
        state_d   = SHIFT;
      end
      // Each device clock fall advances to the next bit; a 0 bit pulls data low.
      SHIFT: begin
        if (clk_fall) begin
          if (bit_idx_q < BIT_IDX_W'(PARITY_IDX)) begin
            data_low_d = ~shreg_q[0];
            shreg_d    = {1'b0, shreg_q[DATA_W-1:1]};
            bit_idx_d  = bit_idx_q + BIT_IDX_W'(1);
          end else if (bit_idx_q == BIT_IDX_W'(PARITY_IDX)) begin
            data_low_d = ~parity_q;
            bit_idx_d  = BIT_IDX_W'(STOP_IDX);
          end else begin
            data_low_d = 1'b0;
            state_d    = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          ack_err_d  = data_level;
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
          state_d    = RELEASE;
        end
      end
      RELEASE: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        if (clk_level && data_level) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog restarts on every device clock while the device owns the clock.
    if (state_q == REQUEST || state_q == SHIFT || state_q == ACK) begin
      if (clk_fall && state_q != REQUEST) begin
        cnt_d = '0;
      end else if (cnt_q == counterBits'(timeoutCycles - 1)) begin
        timeout_d  = 1'b1;
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        state_d    = RELEASE;
      end else begin
        cnt_d = cnt_q + counterBits'(1);
      end
    end
`else
    timeout_d = 1'b0;
`endif
  end

  assign ps2ClkLow     = clk_low_q;
  assign ps2DataLow    = data_low_q;
  assign bus.busy      = busy_q;
  assign bus.rxInhibit = busy_q;
  assign bus.done      = done_q;
  assign bus.ackError  = ack_err_q;
`ifdef PS2_TX_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_transmitter.sv
// Randomized bench for ps2_transmitter with an open-drain PS/2 device model.
module tb_ps2_transmitter;

  localparam int unsigned INHIBIT = 20;
  localparam int unsigned TIMEOUT = 400;
  localparam int unsigned HALF    = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2Clk, ps2Data, ps2ClkLow, ps2DataLow;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int unsigned inh_run = 0;
  int unsigned inh_last = 0;
  int unsigned done_cnt = 0;

  always #5 clk = ~clk;

  ps2_transmitter_if bus ();

  assign ps2Clk  = ~(ps2ClkLow | dev_clk_low);
  assign ps2Data = ~(ps2DataLow | dev_data_low);

  ps2_transmitter #(
    .inhibitCycles (INHIBIT),
    .timeoutCycles (TIMEOUT),
    .counterBits   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2Clk     (ps2Clk),
    .ps2Data    (ps2Data),
    .ps2ClkLow  (ps2ClkLow),
    .ps2DataLow (ps2DataLow),
    .bus        (bus)
  );

  // Measures host clock-low runs and counts done pulses.
  always @(negedge clk) begin
    if (ps2ClkLow) inh_run <= inh_run + 1;
    else begin
      if (inh_run != 0) inh_last <= inh_run;
      inh_run <= 0;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line levels the device should see: 8 data bits LSB first, odd parity, stop.
  function automatic logic [9:0] model_line(input logic [7:0] d);
    logic [9:0] f;
    f[7:0] = d;
    f[8]   = (($countones(d) % 2) == 0);
    f[9]   = 1'b1;
    return f;
  endfunction

  task automatic send_start(input logic [7:0] d);
    @(negedge clk);
    bus.txData  = d;
    bus.txStart = 1'b1;
    @(negedge clk);
    bus.txStart = 1'b0;
    bus.txData  = 8'h00;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(INHIBIT) + 50; i++) begin
      @(negedge clk);
      if (ps2DataLow && !ps2ClkLow) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic dev_pulse();
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input bit poke);
    logic [9:0] seen;
    bit ok;
    int unsigned done_before;
    int n;
    seen = '0;
    send_start(d);
    check("busy_on", bus.busy, 1);
    check("rx_inhibit_on", bus.rxInhibit, 1);
    wait_req(ok);
    check("request_seen", ok, 1);
    if (!ok) return;
    repeat (HALF) @(negedge clk);
    check("inhibit_len", inh_last, INHIBIT);
    done_before = done_cnt;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k <= 10) seen[k-1] = ps2Data;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      if (k == 11) break;
      repeat (HALF) @(negedge clk);
      if (poke && k == 4) begin
        bus.txData  = 8'h55;
        bus.txStart = 1'b1;
        @(negedge clk);
        bus.txStart = 1'b0;
      end
    end
    check("frame_bits", seen, model_line(d));
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", bus.done, 1);
    check("ack_error", bus.ackError, !ack);
    check("timeout_clear", bus.timeout, 0);
    @(negedge clk);
    check("done_pulse", bus.done, 0);
    check("busy_off", bus.busy, 0);
    check("lines_released", {ps2ClkLow, ps2DataLow}, 0);
    check("done_count", done_cnt - done_before, 1);
  endtask

  task automatic reset_midframe();
    bit ok;
    int unsigned done_before;
    send_start(8'h00);
    wait_req(ok);
    check("request_seen_rst", ok, 1);
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= 4; k++) dev_pulse();
    check("data_low_before_rst", ps2DataLow, 1);
    done_before = done_cnt;
    reset = 1'b0;
    #1;
    check("rst_clk_low", ps2ClkLow, 0);
    check("rst_data_low", ps2DataLow, 0);
    check("rst_busy", bus.busy, 0);
    repeat (20) @(negedge clk);
    check("rst_no_done", done_cnt - done_before, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic watchdog_case();
    bit ok;
    int n;
    int unsigned done_before;
    done_before = done_cnt;
    send_start(8'hA5);
`ifdef PS2_TX_TIMEOUT_EN
    wait_req(ok);
    check("request_seen_to", ok, 1);
    n = 0;
    while (!bus.timeout && n < int'(TIMEOUT) + 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, TIMEOUT);
    n = 0;
    while (!bus.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_done", bus.done, 1);
    check("timeout_flag", bus.timeout, 1);
    check("timeout_no_ackerr", bus.ackError, 0);
    @(negedge clk);
    check("timeout_released", {ps2ClkLow, ps2DataLow, bus.busy}, 0);
`else
    ok = 1'b1;
    n = 0;
    repeat (TIMEOUT + 100) @(negedge clk);
    check("no_watchdog_busy", bus.busy, 1);
    check("no_watchdog_done", done_cnt - done_before, 0);
    check("no_watchdog_timeout", bus.timeout, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
`endif
  endtask

  initial begin
    bus.txStart = 1'b0;
    bus.txData  = 8'h00;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_clk_low", ps2ClkLow, 0);
    check("reset_data_low", ps2DataLow, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_ack_error", bus.ackError, 0);
    check("reset_timeout", bus.timeout, 0);
    check("reset_rx_inhibit", bus.rxInhibit, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    run_frame(8'hED, 1'b1, 1'b0);
    run_frame(8'h01, 1'b1, 1'b0);
    run_frame(8'hFF, 1'b1, 1'b0);
    run_frame(8'h00, 1'b1, 1'b0);
    run_frame(8'hED, 1'b0, 1'b0);
    run_frame(8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), 1'b0);
    end
    reset_midframe();
    run_frame(8'hC3, 1'b1, 1'b0);
    watchdog_case();
    run_frame(8'h5A, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_transmitter.md
PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

Interface
REQ-001 Parameter inhibitCycles, default 480: host clock-low inhibit length in clk cycles (120 us at 4 MHz).
REQ-002 Parameter timeoutCycles, default 60000: watchdog limit in clk cycles (15 ms at 4 MHz).
REQ-003 Parameter counterBits, default 16: width of the shared inhibit/timeout counter; it SHALL hold max(inhibitCycles, timeoutCycles).
REQ-004 clk  input  1  system clock (4 MHz domain, same as the PS/2 receiver).
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 ps2Clk  input  1  raw PS/2 clock line level (asynchronous).
REQ-007 ps2Data  input  1  raw PS/2 data line level (asynchronous).
REQ-008 ps2ClkLow  output  1  1 = pull PS/2 clock low (open-drain enable).
REQ-009 ps2DataLow  output  1  1 = pull PS/2 data low (open-drain enable).
REQ-010 txData  input  8  command byte to send (e.g. 0xED LED command).
REQ-011 txStart  input  1  one-cycle request; txData is sampled on the same cycle.
REQ-012 busy  output  1  high from the cycle after an accepted txStart until done.
REQ-013 done  output  1  one-cycle pulse when the frame ends (success or error).
REQ-014 ackError  output  1  valid with done: device did not ACK; held until next accepted txStart.
REQ-015 timeout  output  1  valid with done: watchdog expired; held until next accepted txStart.
REQ-016 rxInhibit  output  1  equals busy; tells the receiver to ignore the lines.

Function
REQ-017 ps2Clk/ps2Data SHALL pass a 2-FF synchronizer; a falling edge is flagged 1 cycle after the synchronized level goes 1->0.
REQ-018 States: IDLE, INHIBIT, REQUEST, SHIFT, ACK, RELEASE.
REQ-019 IDLE: txStart=1 latches txData, computes odd parity (~^txData), clears the counter, ackError and timeout, and moves to INHIBIT; txStart outside IDLE SHALL be ignored.
REQ-020 INHIBIT: ps2ClkLow=1 for exactly inhibitCycles cycles, then REQUEST.
REQ-021 REQUEST: ps2DataLow=1 (start bit), ps2ClkLow=0, bit index=0, then SHIFT.
REQ-022 SHIFT: on each falling edge, drive the next bit (data bits 0..7 LSB first, then parity, then stop=release); a bit value of 0 SHALL drive ps2DataLow=1; after the stop bit, go to ACK.
REQ-023 ACK: on the next falling edge, sample synchronized ps2Data; 0 = ACK, 1 = set ackError; then RELEASE.
REQ-024 RELEASE: ps2ClkLow=ps2DataLow=0; wait until both synchronized lines are high, then pulse done, clear busy, and return to IDLE.
REQ-025 Falling edges in IDLE, INHIBIT or RELEASE SHALL be ignored.
REQ-026 The bit index SHALL be a 4-bit counter 0..9 with no wrap; frame length is fixed at 11 device clocks.

Reset
REQ-027 reset=0 asynchronously forces IDLE; ps2ClkLow, ps2DataLow, busy, done, ackError, timeout, and rxInhibit = 0; shift register, parity, and counters = 0.
REQ-028 Reset mid-frame SHALL release both lines immediately, with no done pulse.

Configuration
REQ-029 With PS2_TX_TIMEOUT_EN defined, the counter restarts at REQUEST and at every falling edge in SHIFT/ACK; reaching timeoutCycles in REQUEST, SHIFT or ACK sets timeout and moves to RELEASE.
REQ-030 Without PS2_TX_TIMEOUT_EN, there is no watchdog, timeout is tied to 0, and the block waits indefinitely for device clocks.

Structure
REQ-031 Package ps2_pkg: state enum, FRAME_BITS=10, PARITY_IDX=8, STOP_IDX=9.
REQ-032 Sub-module ps2_edge_sync: 2-FF synchronizer plus falling-edge flag, instantiated once per line.

Verification
REQ-033 txData=0xED with a device model ACKing: the line shows 1,0,1,1,0,1,1,1, parity 1, stop 1; done=1 and ackError=0.
REQ-034 txData=0x01: parity bit 0; txData=0xFF: parity bit 1; txData=0x00: parity bit 1.
REQ-035 Device leaves data high at the 11th clock -> done=1 and ackError=1, and both lines are released.
REQ-036 With PS2_TX_TIMEOUT_EN and a device that never clocks -> done and timeout=1 exactly timeoutCycles after REQUEST; without the macro, busy stays high.
REQ-037 txStart during SHIFT with txData=0x55 -> ignored; the original byte completes.
REQ-038 reset=0 after the 4th data bit -> ps2ClkLow=ps2DataLow=busy=0 in the same cycle, and no done pulse.
